// File: rtl/ss_edge_gen_pkg.sv
// Shared types and sizing helpers for the single-signal edge generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ss_edge_gen_pkg;

    localparam int DEF_WIDTH    = 2;
    localparam int DEF_GAP      = 2;
    localparam int DEF_MAX_PEND = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Phase counter must hold the larger of WIDTH-1 and GAP-1.
    function automatic int cnt_w(input int width, input int gap);
        int m;
        m = (width > gap) ? width : gap;
        return $clog2(m + 1);
    endfunction

    function automatic int pend_w(input int max_pend);
        return $clog2(max_pend + 1);
    endfunction

endpackage

// File: rtl/ss_edge_gen_pend_cnt.sv
// Saturating up/down count of queued triggers, with full/empty flags.
// Latency: count updates on the clock after inc/dec; flags follow the count.
// Backpressure: inc is ignored at full, dec at empty; inc with dec holds the count.
module ss_pend_cnt #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [CW-1:0] count;

    assign full  = (count == CW'(MAX));
    assign empty = (count == '0);

    // Count moves only when exactly one of inc/dec is active and in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + CW'(1);
        end else if (dec && !inc && !empty) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/ss_edge_gen.sv
// Turns a one-cycle trigger into an active/inactive excursion of set polarity; SS_EDGE_GEN_QUEUE_EN adds a trigger queue.
// Latency: o_signal goes active the cycle after the trigger, WIDTH cycles active then GAP cycles inactive.
// Backpressure: none on i_trig; triggers that cannot be served are discarded with an o_drop pulse.
module ss_edge_gen
    import ss_edge_gen_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int GAP      = DEF_GAP,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pos_edge,
    input  logic i_trig,
    output logic o_signal,
    output logic o_busy,
    output logic o_done,
    output logic o_drop
);

    localparam int            CW     = cnt_w(WIDTH, GAP);
    localparam logic [CW-1:0] W_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] G_LOAD = CW'(GAP - 1);

    if (WIDTH < 1 || WIDTH > 255) begin : g_bad_width
        $error("ss_edge_gen: WIDTH out of range 1..255");
    end
    if (GAP < 1 || GAP > 255) begin : g_bad_gap
        $error("ss_edge_gen: GAP out of range 1..255");
    end
    if (MAX_PEND < 1 || MAX_PEND > 15) begin : g_bad_pend
        $error("ss_edge_gen: MAX_PEND out of range 1..15");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pol;
    logic          busy;
    logic          replay;
    logic          drop_now;

    assign busy   = (state != ST_IDLE);
    assign o_busy = busy;

`ifdef SS_EDGE_GEN_QUEUE_EN
    logic gap_end;
    logic pend_inc;
    logic pend_dec;
    logic pend_full;
    logic pend_empty;

    assign gap_end  = (state == ST_GAP) && (cnt == '0);
    assign pend_inc = i_trig && busy && !pend_full;
    // A trigger landing in the last GAP cycle restarts directly: inc and dec cancel.
    assign pend_dec = gap_end && (!pend_empty || pend_inc);
    assign replay   = pend_dec;
    assign drop_now = i_trig && busy && pend_full;

    ss_pend_cnt #(
        .MAX (MAX_PEND),
        .CW  (pend_w(MAX_PEND))
    ) u_pend (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (pend_inc),
        .dec   (pend_dec),
        .full  (pend_full),
        .empty (pend_empty)
    );
`else
    assign replay   = 1'b0;
    assign drop_now = i_trig && busy;
`endif

    // Excursion sequencer: idle tracks polarity, then ACTIVE for WIDTH, GAP for GAP cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pol      <= 1'b1;
            o_signal <= 1'b0;
            o_done   <= 1'b0;
            o_drop   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_drop <= drop_now;
            case (state)
                ST_IDLE: begin
                    pol <= i_pos_edge;
                    if (i_trig) begin
                        state    <= ST_ACTIVE;
                        cnt      <= W_LOAD;
                        o_signal <= i_pos_edge;
                    end else begin
                        o_signal <= ~i_pos_edge;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt == '0) begin
                        state    <= ST_GAP;
                        cnt      <= G_LOAD;
                        o_signal <= ~pol;
                        o_done   <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        if (replay) begin
                            // Queued excursions reuse the latched polarity.
                            state    <= ST_ACTIVE;
                            cnt      <= W_LOAD;
                            o_signal <= pol;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ss_edge_gen.sv
// Bench for ss_edge_gen: directed scenarios then random triggers/polarity/resets.
// Expected outputs come from a schedule of excursion start cycles kept in queues.
// Outputs are sampled on the falling clock edge; reset assertion is checked 1ns later.
module tb_ss_edge_gen;

    localparam int W    = 2;
    localparam int G    = 2;
    localparam int MP   = 2;
    localparam int NCYC = 8192;
`ifdef SS_EDGE_GEN_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic pos_edge = 1'b1;
    logic trig     = 1'b0;
    logic sig;
    logic busy;
    logic done;
    logic drop;

    always #5 clk = ~clk;

    ss_edge_gen #(
        .WIDTH    (W),
        .GAP      (G),
        .MAX_PEND (MP)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_pos_edge (pos_edge),
        .i_trig     (trig),
        .o_signal   (sig),
        .o_busy     (busy),
        .o_done     (done),
        .o_drop     (drop)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit pos_at  [NCYC];
    bit drop_at [NCYC];
    bit rst_at  [NCYC];
    int ex_start[$];
    bit ex_pol  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Last cycle (end of GAP) of the latest scheduled excursion, -1 if none.
    function automatic int last_end();
        if (ex_start.size() == 0) return -1;
        return ex_start[ex_start.size()-1] + W + G - 1;
    endfunction

    task automatic check_cycle();
        bit e_sig, e_busy, e_done, e_drop;
        e_sig = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_drop = 1'b0;
        while (ex_start.size() > 0 && ex_start[0] + W + G - 1 < cyc - 1) begin
            void'(ex_start.pop_front());
            void'(ex_pol.pop_front());
        end
        if (!rst_at[cyc]) begin
            e_sig  = ~pos_at[cyc-1];
            e_drop = drop_at[cyc];
            foreach (ex_start[i]) begin
                if (cyc >= ex_start[i] && cyc <= ex_start[i] + W + G - 1) begin
                    e_busy = 1'b1;
                    e_sig  = (cyc < ex_start[i] + W) ? ex_pol[i] : ~ex_pol[i];
                    e_done = (cyc == ex_start[i] + W);
                end
            end
        end
        chk("signal", 32'(sig),  32'(e_sig));
        chk("busy",   32'(busy), 32'(e_busy));
        chk("done",   32'(done), 32'(e_done));
        chk("drop",   32'(drop), 32'(e_drop));
    endtask

    // Schedule the consequence of the inputs driven in the current cycle.
    task automatic accept(input bit t, input bit p);
        int le;
        int pend;
        pos_at[cyc] = p;
        if (t) begin
            le = last_end();
            if (le < cyc) begin
                ex_start.push_back(cyc + 1);
                ex_pol.push_back(p);
            end else if (QUEUE) begin
                pend = 0;
                foreach (ex_start[i]) if (ex_start[i] > cyc) pend++;
                if (pend < MP) begin
                    ex_start.push_back(le + 1);
                    ex_pol.push_back(ex_pol[ex_pol.size()-1]);
                end else begin
                    drop_at[cyc+1] = 1'b1;
                end
            end else begin
                drop_at[cyc+1] = 1'b1;
            end
        end
    endtask

    task automatic step(input bit t, input bit p);
        @(negedge clk);
        check_cycle();
        trig     = t;
        pos_edge = p;
        accept(t, p);
        cyc++;
    endtask

    // Hold reset for n cycles; outputs must clear asynchronously.
    task automatic do_reset(input int n);
        ex_start.delete();
        ex_pol.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            trig  = 1'b0;
            #1;
            rst_at[cyc] = 1'b1;
            pos_at[cyc] = pos_edge;
            check_cycle();
            cyc++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bit t;
        bit p;
        pos_edge = 1'b1;
        do_reset(3);

        // Single posedge excursion.
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b1);

        // Negedge polarity held from reset release.
        pos_edge = 1'b0;
        do_reset(2);
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);

        // Back-to-back triggers: queued replay or drops, then overflow.
        repeat (3) step(1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b1);
        repeat (16) step(1'b0, 1'b1);

        // Trigger in the last GAP cycle.
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1);

        // Reset in the middle of ACTIVE, then a normal excursion.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        do_reset(2);
        repeat (2) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b1);

        // Random triggers; polarity changes only while idle; occasional resets.
        for (int k = 0; k < 2500; k++) begin
            t = ($urandom_range(0, 3) == 0);
            p = pos_edge;
            if (last_end() < cyc && $urandom_range(0, 7) == 0) p = ~p;
            if ($urandom_range(0, 299) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                step(t, p);
            end
        end
        repeat (10) step(1'b0, pos_edge);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ss_edge_gen.md
Name: ss_edge_gen

Overview:
- Pulse-to-level encoder; the transmit-side counterpart of the team's single-signal edge detector.
- Converts a one-cycle trigger into a clean, timed excursion on a single output line.
- The excursion has selectable polarity: a posedge then a return, or a negedge then a return.
- It enforces minimum active and inactive times, so a downstream edge detector on the same clock sees exactly one edge of the requested type per trigger.

Parameters:
- WIDTH, 2, cycles o_signal is held at its active level per trigger (legal range 1 to 255).
- GAP, 2, minimum cycles at the inactive level after each active phase (legal range 1 to 255).
- MAX_PEND, 4, depth of the pending-trigger counter (legal range 1 to 15; used only with the queue feature).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_pos_edge  in  1  1 = generate a posedge (idle low, active high); 0 = generate a negedge (idle high, active low).
- i_trig  in  1  one-cycle request for one excursion.
- o_signal  out  1  generated line, registered.
- o_busy  out  1  high while in ACTIVE or GAP.
- o_done  out  1  one-cycle pulse in the first cycle o_signal is back at its inactive level.
- o_drop  out  1  one-cycle pulse when a trigger is discarded.

Behaviour:
- Reset (async, i_rst_n=0):
  - State = IDLE; o_signal=0, o_busy=0, o_done=0, o_drop=0.
  - Latched polarity pol=1; phase counter=0; pending=0.
- IDLE:
  - Every cycle pol <= i_pos_edge and o_signal <= ~i_pos_edge.
  - A polarity change while idle therefore moves the line one cycle later. This is legal but is itself an edge; callers change polarity only while o_busy=0.
- Trigger accepted at the edge ending cycle N:
  - o_signal = pol from cycle N+1 for exactly WIDTH cycles (state ACTIVE, counter counts WIDTH-1 down to 0).
  - Then o_signal = ~pol for GAP cycles (state GAP).
- o_done is high in the first GAP cycle.
- o_busy is high from N+1 through the last GAP cycle.
- End of GAP:
  - If pending>0: go directly to ACTIVE and decrement pending. pol is not re-sampled for queued excursions.
  - Otherwise go to IDLE.
- Transitions: IDLE->ACTIVE on i_trig; ACTIVE->GAP when the counter hits 0; GAP->ACTIVE|IDLE as above.
- i_pos_edge is ignored outside IDLE.
- Trigger while busy, queue feature compiled out: discarded, with o_drop high the next cycle.
- Simultaneous trigger and pending decrement: pending is unchanged.
- Trigger when pending=MAX_PEND: discarded, with o_drop high the next cycle.
- Reset asserted mid-excursion: immediate return to reset values. o_signal drops to 0 even if the active level was 1. No o_done is generated.
- Counter width: $clog2(max(WIDTH,GAP)+1) bits. Pending counter width: $clog2(MAX_PEND+1) bits.

Optional Feature:
- Macro: SS_EDGE_GEN_QUEUE_EN.
- Defined: triggers arriving during ACTIVE or GAP increment pending (saturating at MAX_PEND, overflow gives o_drop) and are replayed back-to-back, separated by the GAP phase.
- Undefined:
  - Any trigger while o_busy=1 is dropped with an o_drop pulse.
  - The pending logic is absent and GAP always exits to IDLE.

Decomposition:
- Package ss_edge_gen_pkg holds:
  - the state enum (IDLE, ACTIVE, GAP; 2-bit);
  - localparam helpers for the counter width;
  - the default WIDTH, GAP and MAX_PEND constants.
- One natural sub-module, ss_pend_cnt: a saturating up/down counter with inc, dec, full and empty outputs. It is instantiated only under SS_EDGE_GEN_QUEUE_EN.

Test Plan:
- Posedge with defaults: i_pos_edge=1, i_trig at cycle 5 -> o_signal=1 in cycles 6-7, 0 in cycles 8-9; o_done high in cycle 8; o_busy high in cycles 6-9; loopback edge detector fires once.
- Negedge: i_pos_edge=0 held from reset release -> o_signal=1 while idle. Trigger at cycle 10 -> o_signal=0 in cycles 11-12, back to 1 at cycle 13.
- Queue on, MAX_PEND=4, triggers at cycles 5,6,7 -> three excursions starting at cycles 6, 10 and 14; o_drop never asserts; pending returns to 0.
- Overflow, queue on, MAX_PEND=1: triggers at cycles 5,6,7 -> excursions at cycles 6 and 10; o_drop high at cycle 8.
- Queue off: triggers at cycles 5 and 7 -> one excursion only; o_drop high at cycle 8.
- Reset at cycle 7 mid-ACTIVE (pos=1) -> o_signal=0 asynchronously; o_busy=0; no o_done; a new trigger after release produces a normal excursion.
